// File: rtl/conv1d_cfu_pkg.sv
// Shared types for the 1-D convolution SIMD CFU.
//   cmd_e    : command codes carried on the 7-bit cmd port
//   state_e  : control FSM states
//   prod_width(): width of one lane product (int8 weight x 9-bit activation)
package conv1d_cfu_pkg;

    typedef enum logic [6:0] {
        CLEAR  = 7'd0,
        LOADK  = 7'd1,
        SETLEN = 7'd2,
        SETOFS = 7'd3,
        MAC    = 7'd4,
        READ   = 7'd5
    } cmd_e;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        ADD,
        RESP
    } state_e;

    localparam int BYTE_SIZE_DEFAULT = 8;
    localparam int PROD_WIDTH        = 2 * BYTE_SIZE_DEFAULT + 1;

    // A BYTE_SIZE-bit signed weight times a (BYTE_SIZE+1)-bit signed operand.
    function automatic int prod_width(input int byte_size);
        return 2 * byte_size + 1;
    endfunction

endpackage

// File: rtl/conv1d_simd_mac.sv
// LANES-wide signed dot-product datapath.
//   clk, rst : clock and asynchronous active-high reset
//   load     : capture the lane products this cycle
//   weights  : packed signed weights, lane 0 in the low bits
//   acts     : packed signed activations, same lane order
//   offset   : signed activation offset, added before multiplying
//   sum      : sign-extended sum of the registered products
module conv1d_simd_mac
    import conv1d_cfu_pkg::*;
#(
    parameter int BYTE_SIZE = 8,
    parameter int LANES     = 4,
    parameter int ACC_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         load,
    input  logic [LANES*BYTE_SIZE-1:0]   weights,
    input  logic [LANES*BYTE_SIZE-1:0]   acts,
    input  logic signed [BYTE_SIZE:0]    offset,
    output logic [ACC_WIDTH-1:0]         sum
);

    localparam int PW = prod_width(BYTE_SIZE);

    logic [LANES*ACC_WIDTH-1:0] ext_flat;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic signed [BYTE_SIZE-1:0] w;
            logic signed [BYTE_SIZE:0]   a_ofs;
            logic signed [PW-1:0]        prod_next;
            logic signed [PW-1:0]        prod_reg;

            assign w = weights[gi*BYTE_SIZE +: BYTE_SIZE];
            // Activation plus offset deliberately wraps at BYTE_SIZE+1 bits.
            assign a_ofs = $signed({acts[gi*BYTE_SIZE+BYTE_SIZE-1],
                                    acts[gi*BYTE_SIZE +: BYTE_SIZE]}) + offset;
            assign prod_next = PW'(w) * PW'(a_ofs);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    prod_reg <= '0;
                end else if (load) begin
                    prod_reg <= prod_next;
                end
            end

            assign ext_flat[gi*ACC_WIDTH +: ACC_WIDTH] = ACC_WIDTH'(prod_reg);
        end
    endgenerate

    always_comb begin
        sum = '0;
        for (int i = 0; i < LANES; i++) begin
            sum = sum + ext_flat[i*ACC_WIDTH +: ACC_WIDTH];
        end
    end

endmodule

// File: rtl/conv1d_simd_cfu.sv
// 1-D int8 convolution CFU for a RISC-V custom-instruction port.
//   clk, rst            : clock, asynchronous active-high reset
//   en, cmd             : command strobe and code; taken only while output_buffer_valid=1
//   inp0                : index / length / offset operand
//   inp1                : packed weights (LOADK) or packed activations (MAC)
//   ret                 : command result, held until the next completion
//   output_buffer_valid : 1 = idle with result ready, 0 = busy
module conv1d_simd_cfu
    import conv1d_cfu_pkg::*;
#(
    parameter int BYTE_SIZE    = 8,
    parameter int INT32_SIZE   = 32,
    parameter int LANES        = 4,
    parameter int KERNEL_DEPTH = 16,
    parameter int ACC_WIDTH    = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [6:0]            cmd,
    input  logic [INT32_SIZE-1:0] inp0,
    input  logic [INT32_SIZE-1:0] inp1,
    output logic [INT32_SIZE-1:0] ret,
    output logic                  output_buffer_valid
);

    localparam int IDX_W = $clog2(KERNEL_DEPTH);
    localparam int LEN_W = IDX_W + 1;
    localparam int OFS_W = BYTE_SIZE + 1;
    localparam int ARG_W = (OFS_W > IDX_W) ? OFS_W : IDX_W;

    logic [INT32_SIZE-1:0]  kernel_reg [KERNEL_DEPTH];
    state_e                 state_reg;
    logic [6:0]             cmd_reg;
    logic [ARG_W-1:0]       arg_reg;
    logic [INT32_SIZE-1:0]  data_reg;
    logic [IDX_W-1:0]       ptr_reg;
    logic [LEN_W-1:0]       len_reg;
    logic signed [OFS_W-1:0] offset_reg;
    logic [ACC_WIDTH-1:0]   acc_reg;
    logic [INT32_SIZE-1:0]  ret_reg;
    logic                   valid_reg;

    logic [ACC_WIDTH-1:0]   mac_sum;
    logic [ACC_WIDTH-1:0]   acc_next;
    logic [IDX_W-1:0]       ptr_next;
    logic [IDX_W-1:0]       arg_idx;
    logic [LEN_W-1:0]       len_next;
    logic                   unused_inp0;

    assign unused_inp0 = ^inp0[INT32_SIZE-1:ARG_W];

    conv1d_simd_mac #(
        .BYTE_SIZE (BYTE_SIZE),
        .LANES     (LANES),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_mac (
        .clk     (clk),
        .rst     (rst),
        .load    (state_reg == MUL),
        .weights (kernel_reg[ptr_reg]),
        .acts    (data_reg),
        .offset  (offset_reg),
        .sum     (mac_sum)
    );

    assign acc_next = acc_reg + mac_sum;
    assign ptr_next = ({1'b0, ptr_reg} == len_reg - LEN_W'(1)) ? '0 : ptr_reg + IDX_W'(1);
    assign arg_idx  = arg_reg[IDX_W-1:0];
    // A length field of zero selects the full buffer.
    assign len_next = (arg_idx == '0) ? LEN_W'(KERNEL_DEPTH) : {1'b0, arg_idx};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < KERNEL_DEPTH; i++) begin
                kernel_reg[i] <= '0;
            end
            state_reg  <= IDLE;
            cmd_reg    <= '0;
            arg_reg    <= '0;
            data_reg   <= '0;
            ptr_reg    <= '0;
            len_reg    <= LEN_W'(KERNEL_DEPTH);
            offset_reg <= '0;
            acc_reg    <= '0;
            ret_reg    <= '0;
            valid_reg  <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (en) begin
                        cmd_reg   <= cmd;
                        arg_reg   <= inp0[ARG_W-1:0];
                        data_reg  <= inp1;
                        valid_reg <= 1'b0;
                        state_reg <= (cmd == MAC) ? MUL : RESP;
                    end
                end
                MUL: begin
                    state_reg <= ADD;
                end
                ADD: begin
                    acc_reg   <= acc_next;
                    ret_reg   <= acc_next[INT32_SIZE-1:0];
                    ptr_reg   <= ptr_next;
                    valid_reg <= 1'b1;
                    state_reg <= IDLE;
                end
                RESP: begin
                    case (cmd_reg)
                        CLEAR: begin
                            ret_reg <= acc_reg[INT32_SIZE-1:0];
                            acc_reg <= '0;
                            ptr_reg <= '0;
                        end
                        LOADK: begin
                            kernel_reg[arg_idx] <= data_reg;
                            ret_reg <= INT32_SIZE'(arg_idx);
                        end
                        SETLEN: begin
                            len_reg <= len_next;
                            ptr_reg <= '0;
                            ret_reg <= INT32_SIZE'(len_next);
                        end
                        SETOFS: begin
                            offset_reg <= arg_reg[OFS_W-1:0];
                            ret_reg <= {{(INT32_SIZE-OFS_W){arg_reg[OFS_W-1]}}, arg_reg[OFS_W-1:0]};
                        end
                        READ: begin
                            ret_reg <= acc_reg[INT32_SIZE-1:0];
                        end
                        default: begin
                            ret_reg <= '0;
                        end
                    endcase
                    valid_reg <= 1'b1;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                    valid_reg <= 1'b1;
                end
            endcase
        end
    end

    assign ret                 = ret_reg;
    assign output_buffer_valid = valid_reg;

endmodule

// File: tb/tb_conv1d_simd_cfu.sv
module tb_conv1d_simd_cfu;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [6:0]  cmd;
    logic [31:0] inp0;
    logic [31:0] inp1;
    logic [31:0] ret;
    logic        valid;

    always #5 clk = ~clk;

    conv1d_simd_cfu dut (
        .clk                 (clk),
        .rst                 (rst),
        .en                  (en),
        .cmd                 (cmd),
        .inp0                (inp0),
        .inp1                (inp1),
        .ret                 (ret),
        .output_buffer_valid (valid)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Behavioural model: plain integer arithmetic on the documented rules.
    logic [31:0] m_kern [16];
    logic [31:0] m_acc;
    int          m_ptr;
    int          m_len;
    int          m_ofs;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_kern[i] = 32'd0;
        m_acc = 32'd0;
        m_ptr = 0;
        m_len = 16;
        m_ofs = 0;
    endtask

    function automatic int sbyte(input logic [31:0] w, input int i);
        int v;
        v = int'((w >> (8 * i)) & 32'hFF);
        if (v >= 128) v -= 256;
        return v;
    endfunction

    task automatic model_cmd(input logic [6:0] c, input logic [31:0] a0, input logic [31:0] a1,
                             output logic [31:0] e);
        int s, t, v;
        case (c)
            7'd0: begin e = m_acc; m_acc = 32'd0; m_ptr = 0; end
            7'd1: begin m_kern[a0 % 16] = a1; e = a0 % 16; end
            7'd2: begin
                v = int'(a0 % 16);
                if (v == 0) v = 16;
                m_len = v; m_ptr = 0; e = v;
            end
            7'd3: begin
                v = int'(a0 % 512);
                if (v >= 256) v -= 512;
                m_ofs = v; e = v;
            end
            7'd4: begin
                s = 0;
                for (int i = 0; i < 4; i++) begin
                    t = sbyte(a1, i) + m_ofs;
                    t = ((t + 256 + 512) % 512) - 256;
                    s += sbyte(m_kern[m_ptr], i) * t;
                end
                m_acc = m_acc + s;
                m_ptr = (m_ptr + 1) % m_len;
                e = m_acc;
            end
            7'd5: e = m_acc;
            default: e = 32'd0;
        endcase
    endtask

    task automatic do_cmd(input logic [6:0] c, input logic [31:0] a0, input logic [31:0] a1,
                          output logic [31:0] r);
        int cyc;
        @(negedge clk);
        check("idle_before", {31'd0, valid}, 32'd1);
        en = 1'b1; cmd = c; inp0 = a0; inp1 = a1;
        @(posedge clk); #1;
        en = 1'b0;
        check("busy_after_accept", {31'd0, valid}, 32'd0);
        cyc = 0;
        while (!valid && cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("latency", cyc, (c == 7'd4) ? 32'd2 : 32'd1);
        r = ret;
    endtask

    task automatic run(input string tag, input logic [6:0] c, input logic [31:0] a0,
                       input logic [31:0] a1, output logic [31:0] r);
        logic [31:0] e;
        model_cmd(c, a0, a1, e);
        do_cmd(c, a0, a1, r);
        $display("%s cmd=%0d inp0=0x%08h inp1=0x%08h ret=0x%08h exp=0x%08h", tag, c, a0, a1, r, e);
        check(tag, r, e);
    endtask

    logic [31:0] r, e1, e2;
    logic [6:0]  rc;
    bit   [5:0]  v_pat = 6'b100100;

    initial begin
        rst = 1'b1; en = 1'b0; cmd = 7'd0; inp0 = 32'd0; inp1 = 32'd0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", {31'd0, valid}, 32'd1);
        check("reset_ret", ret, 32'd0);
        @(negedge clk); rst = 1'b0;

        // Reset in the middle of a MAC.
        run("pre_loadk", 7'd1, 32'd5, 32'h11223344, r);
        run("pre_setlen", 7'd2, 32'd3, 32'd0, r);
        @(negedge clk);
        en = 1'b1; cmd = 7'd4; inp0 = 32'd0; inp1 = 32'h01010101;
        @(posedge clk); #1;
        en = 1'b0; rst = 1'b1;
        #1;
        check("midmac_rst_valid", {31'd0, valid}, 32'd1);
        check("midmac_rst_ret", ret, 32'd0);
        @(negedge clk); rst = 1'b0;
        model_reset();
        run("post_rst_read", 7'd5, 32'd0, 32'd0, r);

        // LOADK index wraps; MAC on word 2.
        run("loadk18", 7'd1, 32'd18, 32'h04030201, r);
        check("loadk18_idx", r, 32'd2);
        run("mac_w0", 7'd4, 32'd0, 32'h01010101, r);
        run("mac_w1", 7'd4, 32'd0, 32'h01010101, r);
        run("mac_w2", 7'd4, 32'd0, 32'h01010101, r);
        check("mac_w2_const", r, 32'd10);

        // Offset -1 cancels activation 1.
        run("setofs_m1", 7'd3, 32'h1FF, 32'd0, r);
        check("setofs_m1_const", r, 32'hFFFFFFFF);
        run("clr_a", 7'd0, 32'd0, 32'd0, r);
        run("loadk0", 7'd1, 32'd0, 32'h01010101, r);
        run("setlen1", 7'd2, 32'd1, 32'd0, r);
        run("mac_ofs", 7'd4, 32'd0, 32'h01010101, r);
        check("mac_ofs_const", r, 32'd0);
        run("setofs0", 7'd3, 32'd0, 32'd0, r);
        run("loadk0_neg", 7'd1, 32'd0, 32'h80808080, r);
        run("clr_b", 7'd0, 32'd0, 32'd0, r);
        run("mac_extreme", 7'd4, 32'd0, 32'h7F7F7F7F, r);
        check("mac_extreme_const", r, 32'hFFFF0200);

        // Length 3 wrap.
        run("clr_c", 7'd0, 32'd0, 32'd0, r);
        run("setlen3", 7'd2, 32'd3, 32'd0, r);
        run("lk_a", 7'd1, 32'd0, 32'd1, r);
        run("lk_b", 7'd1, 32'd1, 32'd2, r);
        run("lk_c", 7'd1, 32'd2, 32'd3, r);
        run("len3_mac1", 7'd4, 32'd0, 32'd1, r); check("len3_seq1", r, 32'd1);
        run("len3_mac2", 7'd4, 32'd0, 32'd1, r); check("len3_seq2", r, 32'd3);
        run("len3_mac3", 7'd4, 32'd0, 32'd1, r); check("len3_seq3", r, 32'd6);
        run("len3_mac4", 7'd4, 32'd0, 32'd1, r); check("len3_seq4", r, 32'd7);
        run("setlen0", 7'd2, 32'd0, 32'd0, r);
        check("setlen0_const", r, 32'd16);

        // en held high: accepts only on valid=1 edges.
        model_cmd(7'd4, 32'd0, 32'h05FB0302, e1);
        model_cmd(7'd4, 32'd0, 32'h05FB0302, e2);
        @(negedge clk);
        check("hold_v0", {31'd0, valid}, 32'd1);
        en = 1'b1; cmd = 7'd4; inp0 = 32'd0; inp1 = 32'h05FB0302;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            check($sformatf("hold_valid%0d", k), {31'd0, valid}, {31'd0, v_pat[k]});
            if (k == 2) check("hold_ret1", ret, e1);
            if (k == 5) check("hold_ret2", ret, e2);
        end
        @(negedge clk); en = 1'b0;
        $display("hold_en two MACs ret=0x%08h exp=0x%08h", ret, e2);

        // Randomised traffic.
        for (int n = 0; n < 300; n++) begin
            rc = 7'($urandom_range(0, 6));
            if (rc == 7'd6) rc = 7'($urandom_range(6, 127));
            run($sformatf("rnd%0d", n), rc, $urandom, $urandom, r);
        end

        // Drive the accumulator up to just below 2^31, then wrap.
        run("w_ofs", 7'd3, 32'h180, 32'd0, r);
        run("w_lk", 7'd1, 32'd0, 32'h80808080, r);
        run("w_len", 7'd2, 32'd1, 32'd0, r);
        run("w_clr", 7'd0, 32'd0, 32'd0, r);
        for (int n = 0; n < 16383; n++) model_cmd(7'd4, 32'd0, 32'h80808080, e1);
        @(negedge clk);
        en = 1'b1; cmd = 7'd4; inp0 = 32'd0; inp1 = 32'h80808080;
        repeat (3 * 16383) @(posedge clk);
        #1;
        check("stream_valid", {31'd0, valid}, 32'd1);
        check("stream_ret", ret, e1);
        check("stream_ret_const", ret, 32'h7FFE0000);
        @(negedge clk); en = 1'b0;
        $display("stream 16383 MACs ret=0x%08h exp=0x%08h", ret, e1);
        run("wrap_mac", 7'd4, 32'd0, 32'h80808080, r);
        check("wrap_const", r, 32'h80000000);
        run("wrap_clr", 7'd0, 32'd0, 32'd0, r);
        check("wrap_clr_const", r, 32'h80000000);
        run("wrap_read", 7'd5, 32'd0, 32'd0, r);
        check("wrap_read_const", r, 32'd0);
        run("bad_cmd", 7'h55, 32'hDEADBEEF, 32'hCAFEF00D, r);
        check("bad_cmd_const", r, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
